// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream stage, the skid stage and the downstream stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface pipe_stage_skid_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rn;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rn;
  logic [CW-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_rn, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_rn, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_rn, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_rn, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: the main entry drives the outputs, the skid entry
// absorbs one beat when downstream stalls, so in_ready never depends on out_ready.
module pipe_stage_skid #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int CW  = 3,
  parameter int SCW = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  pipe_stage_skid_if.slave  bus,
  output logic [SCW-1:0]    stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t        state_r, state_nx;
  logic [DW-1:0] main_data_r, skid_data_r;
  logic [RW-1:0] main_rn_r,   skid_rn_r;
  logic [CW-1:0] main_ctrl_r, skid_ctrl_r;

  logic in_ready_s, out_valid_s, accept_s, transfer_s;
  logic load_main_s, load_skid_s, move_skid_s, clr_ctrl_s;

  assign in_ready_s  = (state_r != ST_TWO) & ~flush;
  assign out_valid_s = (state_r != ST_EMPTY);
  assign accept_s    = bus.in_valid & in_ready_s;
  assign transfer_s  = out_valid_s & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = main_data_r;
  assign bus.out_rn    = main_rn_r;
  // Bubbles must never carry live control bits downstream (e.g. a stray register write).
  assign bus.out_ctrl  = out_valid_s ? main_ctrl_r : {CW{1'b0}};

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state and entry-update decode; flush overrides every handshake.
  always_comb begin
    state_nx    = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    move_skid_s = 1'b0;
    clr_ctrl_s  = 1'b0;
    if (flush) begin
      state_nx   = ST_EMPTY;
      clr_ctrl_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx    = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && transfer_s) begin
            state_nx    = ST_ONE;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            state_nx    = ST_TWO;
            load_skid_s = 1'b1;
          end else if (transfer_s) begin
            state_nx = ST_EMPTY;
          end else begin
            state_nx = ST_ONE;
          end
        end
        ST_TWO: begin
          if (transfer_s) begin
            state_nx    = ST_ONE;
            move_skid_s = 1'b1;
          end else begin
            state_nx = ST_TWO;
          end
        end
        default: begin
          state_nx   = ST_EMPTY;
          clr_ctrl_s = 1'b1;
        end
      endcase
    end
  end

  // Main and skid entries; payload is kept on flush so out_data/out_rn stay stable.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_data_r <= {DW{1'b0}};
      main_rn_r   <= {RW{1'b0}};
      main_ctrl_r <= {CW{1'b0}};
      skid_data_r <= {DW{1'b0}};
      skid_rn_r   <= {RW{1'b0}};
      skid_ctrl_r <= {CW{1'b0}};
    end else if (clr_ctrl_s) begin
      main_ctrl_r <= {CW{1'b0}};
      skid_ctrl_r <= {CW{1'b0}};
    end else begin
      if (load_main_s) begin
        main_data_r <= bus.in_data;
        main_rn_r   <= bus.in_rn;
        main_ctrl_r <= bus.in_ctrl;
      end else if (move_skid_s) begin
        main_data_r <= skid_data_r;
        main_rn_r   <= skid_rn_r;
        main_ctrl_r <= skid_ctrl_r;
      end
      if (load_skid_s) begin
        skid_data_r <= bus.in_data;
        skid_rn_r   <= bus.in_rn;
        skid_ctrl_r <= bus.in_ctrl;
      end
    end
  end

  // Saturating downstream-stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= {SCW{1'b0}};
    end else if (out_valid_s && !bus.out_ready && (stall_cnt != {SCW{1'b1}})) begin
      stall_cnt <= stall_cnt + SCW'(1'b1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for the cycle-by-cycle flows,
// plus hand-written sequences for stall saturation and mid-cycle asynchronous reset.
module tb_pipe_stage_skid;

  localparam int DW = 32, RW = 5, CW = 3, SCW = 4;

  logic clk = 1'b0;
  logic clrn;
  logic flush;
  logic [SCW-1:0] stall_cnt;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

  pipe_stage_skid #(.DW(DW), .RW(RW), .CW(CW), .SCW(SCW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [4:0]  rn;
    logic [2:0]  c;
    logic        ordy;
    logic        fl;
    logic        e_iry;
    logic        e_ov;
    logic [31:0] e_od;
    logic [4:0]  e_rn;
    logic [2:0]  e_c;
    logic [3:0]  e_st;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [4:0] rn,
                              input logic [2:0] c, input logic ordy, input logic fl,
                              input logic iry, input logic ov, input logic [31:0] od,
                              input logic [4:0] orn, input logic [2:0] oc, input logic [3:0] st);
    vec_t v;
    v.iv = iv; v.d = d; v.rn = rn; v.c = c; v.ordy = ordy; v.fl = fl;
    v.e_iry = iry; v.e_ov = ov; v.e_od = od; v.e_rn = orn; v.e_c = oc; v.e_st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic iry, input logic ov, input logic [31:0] od,
                         input logic [4:0] orn, input logic [2:0] oc, input logic [3:0] st);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'(iry));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, " out_data"},  bus.out_data,       od);
    chk({tag, " out_rn"},    32'(bus.out_rn),    32'(orn));
    chk({tag, " out_ctrl"},  32'(bus.out_ctrl),  32'(oc));
    chk({tag, " stall_cnt"}, 32'(stall_cnt),     32'(st));
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [4:0] rn,
                       input logic [2:0] c, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_rn     = rn;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    // Single beat
    vecs[0]  = mk(1'b1, 32'h12345678, 5'd7, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 3'd0, 4'd0);
    vecs[1]  = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 5'd7, 3'b101, 4'd0);
    vecs[2]  = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 5'd7, 3'd0, 4'd0);
    // Back-to-back beats 1..8, each shows up one cycle after it is presented
    vecs[3]  = mk(1'b1, 32'd1, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 5'd7, 3'd0, 4'd0);
    for (int k = 2; k <= 8; k++) begin
      vecs[k+2] = mk(1'b1, 32'(k), 5'(k), 3'b010, 1'b1, 1'b0,
                     1'b1, 1'b1, 32'(k-1), 5'(k-1), 3'b010, 4'd0);
    end
    vecs[11] = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8, 5'd8, 3'b010, 4'd0);
    // Skid: A, B accepted under stall, C held off until release
    vecs[12] = mk(1'b1, 32'hA, 5'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8, 5'd8, 3'd0, 4'd0);
    vecs[13] = mk(1'b1, 32'hB, 5'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 5'd1, 3'd1, 4'd0);
    vecs[14] = mk(1'b1, 32'hC, 5'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 5'd1, 3'd1, 4'd1);
    vecs[15] = mk(1'b1, 32'hC, 5'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 5'd1, 3'd1, 4'd2);
    vecs[16] = mk(1'b1, 32'hC, 5'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 5'd1, 3'd1, 4'd3);
    vecs[17] = mk(1'b1, 32'hC, 5'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 5'd2, 3'd2, 4'd3);
    vecs[18] = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 5'd3, 3'd3, 4'd3);
    vecs[19] = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC, 5'd3, 3'd0, 4'd3);
    // Flush from TWO with a beat offered in the flush cycle
    vecs[20] = mk(1'b1, 32'h11, 5'd4, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC, 5'd3, 3'd0, 4'd3);
    vecs[21] = mk(1'b1, 32'h22, 5'd5, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 5'd4, 3'd7, 4'd3);
    vecs[22] = mk(1'b1, 32'h33, 5'd6, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 5'd4, 3'd7, 4'd4);
    vecs[23] = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 5'd4, 3'd0, 4'd5);
    vecs[24] = mk(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 5'd4, 3'd0, 4'd5);

    // Reset state, checked while clrn is held low
    clrn = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("reset", 1'b1, 1'b0, 32'h0, 5'd0, 3'd0, 4'd0);
    @(posedge clk); #1;
    clrn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].rn, vecs[i].c, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_iry, vecs[i].e_ov, vecs[i].e_od,
              vecs[i].e_rn, vecs[i].e_c, vecs[i].e_st);
      @(posedge clk); #1;
    end

    // Saturation: one beat parked with out_ready low; counter resumes from 5
    drive(1'b1, 32'h44, 5'd9, 3'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("sat pre-limit stall_cnt", 32'(stall_cnt), 32'd14);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk_all("sat", 1'b1, 1'b1, 32'h44, 5'd9, 3'd1, 4'd15);
    @(posedge clk); #1;

    // Fill the skid entry, then pulse clrn low mid-cycle
    drive(1'b1, 32'h55, 5'd10, 3'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("two in_ready", 32'(bus.in_ready), 32'd0);
    #1 clrn = 1'b0;
    #1;
    chk_all("async rst", 1'b1, 1'b0, 32'h0, 5'd0, 3'd0, 4'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    clrn = 1'b1;
    @(negedge clk);
    chk_all("post rst", 1'b1, 1'b0, 32'h0, 5'd0, 3'd0, 4'd0);
    @(posedge clk); #1;
    drive(1'b1, 32'h66, 5'd11, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("post rst idle out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("post rst beat", 1'b1, 1'b1, 32'h66, 5'd11, 3'd4, 4'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DW, default 32: data payload width (ALU result, store data).
REQ-002 SHALL have parameter RW, default 5: destination register number width.
REQ-003 SHALL have parameter CW, default 3: control-bit width (e.g. wreg, m2reg, wmem).
REQ-004 SHALL have parameter SCW, default 16: stall counter width.
REQ-005 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port clrn  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port flush  in  1  synchronous pipeline flush request.
REQ-008 SHALL have port in_valid  in  1  upstream stage presents a beat.
REQ-009 SHALL have port in_ready  out  1  block accepts a beat this cycle.
REQ-010 SHALL have port in_data  in  DW  upstream payload.
REQ-011 SHALL have port in_rn  in  RW  upstream destination register number.
REQ-012 SHALL have port in_ctrl  in  CW  upstream control bits.
REQ-013 SHALL have port out_valid  out  1  beat available to downstream stage.
REQ-014 SHALL have port out_ready  in  1  downstream stage accepts a beat.
REQ-015 SHALL have port out_data  out  DW  payload of head beat.
REQ-016 SHALL have port out_rn  out  RW  register number of head beat.
REQ-017 SHALL have port out_ctrl  out  CW  control bits of head beat, gated.
REQ-018 SHALL have port stall_cnt  out  SCW  count of downstream-stall cycles.

Function
REQ-019 SHALL hold two entries, main (drives outputs) and skid, tracked by state EMPTY / ONE / TWO.
REQ-020 SHALL define accept = in_valid & in_ready and transfer = out_valid & out_ready.
REQ-021 SHALL drive in_ready = (state != TWO) & !flush, and out_valid = (state != EMPTY).
REQ-022 SHALL, in EMPTY: accept loads main, goes to ONE; otherwise stays in EMPTY.
REQ-023 SHALL, in ONE: accept & transfer loads main from input, stays ONE; accept only loads skid, goes TWO; transfer only goes EMPTY; neither holds.
REQ-024 SHALL, in TWO: transfer moves skid to main, goes ONE; otherwise holds, with no input accepted.
REQ-025 SHALL provide one-cycle latency from accept in EMPTY to out_valid, and full throughput (one beat per cycle) while out_ready=1.
REQ-026 SHALL preserve beat order; a beat is never duplicated or dropped except by flush.
REQ-027 SHALL force out_ctrl to all zeros whenever out_valid=0 (bubble gating); out_data and out_rn retain the last main contents.
REQ-028 SHALL, on flush=1 at a clock edge, go to EMPTY and clear the main and skid control bits, with priority over any accept or transfer in that cycle; the input beat in that cycle is not accepted.
REQ-029 SHALL increment stall_cnt on each cycle with out_valid=1 & out_ready=0, saturate at all ones, and hold otherwise; flush does not clear it.
REQ-030 SHALL hold payload and state unchanged when out_ready=0 and in_ready=0.

Reset
REQ-031 SHALL, while clrn=0, asynchronously force state EMPTY, all entry registers to 0, out_valid=0, out_ctrl=0, out_data=0, out_rn=0, and stall_cnt=0.
REQ-032 SHALL present in_ready=1 in the first cycle after clrn deasserts, provided flush=0.
REQ-033 SHALL, on clrn assertion mid-operation (any state), discard both entries with no partial output.

Verification
REQ-034 SHALL verify single beat: EMPTY, in_data=0x12345678, rn=7, ctrl=3'b101, out_ready=1 -> next cycle out_valid=1 with the same values; the following cycle out_valid=0 and out_ctrl=0.
REQ-035 SHALL verify back-to-back: 8 beats of data 1..8 with out_ready=1 -> 8 consecutive outputs 1..8 with no bubbles.
REQ-036 SHALL verify skid: beats A=0xA, B=0xB, C=0xC presented while out_ready=0 -> A and B accepted, in_ready=0 with C held, stall_cnt counts up; releasing out_ready gives A, B, C in order.
REQ-037 SHALL verify flush: state TWO with flush=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flushed-cycle input never appears.
REQ-038 SHALL verify saturation: SCW=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
REQ-039 SHALL verify async reset: clrn pulsed low mid-cycle in state TWO -> outputs go to 0 immediately, then state EMPTY with in_ready=1.
